// File: rtl/sevseg_scan_arbiter.sv
// sevseg_scan_arbiter: 8-digit 7-segment scanner shared by three prioritised requesters with frame-granular arbitration.
// Optional SEVSEG_LZ_BLANK_EN blanks leading zero digits.
module sevseg_scan_arbiter #(
   parameter int DWELL_FRAMES = 4
) (
   input  logic        clk_7seg,
   input  logic        Rst,
   input  logic [2:0]  req,
   input  logic [31:0] data0,
   input  logic [31:0] data1,
   input  logic [31:0] data2,
   output logic [7:0]  an,
   output logic [6:0]  sev_out,
   output logic [2:0]  grant,
   output logic        frame_tick
);
   typedef enum logic {IDLE, SCAN} state_t;
   state_t      state_q, state_d;
   logic [2:0]  dig_q, dig_d, grant_q, grant_d, pend_hi;
   logic [3:0]  dwell_q, dwell_d, dwell_inc, nib;
   logic [31:0] snap_q, snap_d;
   logic        lit;
`ifdef SEVSEG_LZ_BLANK_EN
   logic [2:0]  hi;
`endif
   function automatic logic [2:0] pe(input logic [2:0] r);
      return r[0] ? 3'b001 : r[1] ? 3'b010 : r[2] ? 3'b100 : 3'b000;
   endfunction
   function automatic logic [6:0] seg(input logic [3:0] n);
      case (n)
         4'h0: return 7'b0000001;
         4'h1: return 7'b1001111;
         4'h2: return 7'b0010010;
         4'h3: return 7'b0000110;
         4'h4: return 7'b1001100;
         4'h5: return 7'b0100100;
         4'h6: return 7'b0100000;
         4'h7: return 7'b0001111;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0000100;
         4'hA: return 7'b0001000;
         4'hB: return 7'b1100000;
         4'hC: return 7'b0110001;
         4'hD: return 7'b1000010;
         4'hE: return 7'b0110000;
         default: return 7'b0111000;
      endcase
   endfunction
   always_comb begin
      state_d   = state_q;
      dig_d     = dig_q;
      grant_d   = grant_q;
      dwell_d   = dwell_q;
      snap_d    = snap_q;
      dwell_inc = (dwell_q >= 4'(DWELL_FRAMES)) ? dwell_q : dwell_q + 4'd1;
      // requesters with a lower index than the owner outrank it
      pend_hi   = req & (grant_q - 3'd1);
      if (state_q == IDLE) begin
         if (|req) begin
            state_d = SCAN;
            dig_d   = 3'd0;
            dwell_d = 4'd0;
            grant_d = pe(req);
            snap_d  = grant_d[0] ? data0 : grant_d[1] ? data1 : data2;
         end
      end else begin
         dig_d = dig_q + 3'd1;
         if (dig_q == 3'd7) begin
            if (~|(req & grant_q)) begin
               grant_d = pe(req);
               dwell_d = 4'd0;
               state_d = |req ? SCAN : IDLE;
            end else if (|pend_hi && dwell_inc == 4'(DWELL_FRAMES)) begin
               grant_d = pe(req);
               dwell_d = 4'd0;
            end else
               dwell_d = dwell_inc;
            snap_d = grant_d[0] ? data0 : grant_d[1] ? data1 : grant_d[2] ? data2 : 32'h0;
         end
      end
   end
   always_comb begin
      nib = snap_q[4*dig_q +: 4];
`ifdef SEVSEG_LZ_BLANK_EN
      hi = 3'd0;
      for (int i = 1; i < 8; i++)
         if (snap_q[4*i +: 4] != 4'h0) hi = 3'(i);
      lit = dig_q <= hi;
`else
      lit = 1'b1;
`endif
      an         = (state_q == SCAN && lit) ? ~(8'b1 << dig_q) : 8'hFF;
      sev_out    = (state_q == SCAN && lit) ? seg(nib) : 7'h7F;
      grant      = grant_q;
      frame_tick = state_q == SCAN && dig_q == 3'd7;
   end
   always_ff @(posedge clk_7seg) begin
      if (Rst) begin
         state_q <= IDLE;
         dig_q   <= 3'd0;
         grant_q <= 3'd0;
         dwell_q <= 4'd0;
         snap_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         dig_q   <= dig_d;
         grant_q <= grant_d;
         dwell_q <= dwell_d;
         snap_q  <= snap_d;
      end
   end
endmodule

// File: tb/tb_sevseg_scan_arbiter.sv
// tb_sevseg_scan_arbiter: randomized scoreboard bench for sevseg_scan_arbiter against an abstract display model.
module tb_sevseg_scan_arbiter;
   localparam int D = 4;
   logic        clk_7seg = 0, Rst = 1;
   logic [2:0]  req = 0;
   logic [31:0] data0 = 0, data1 = 0, data2 = 0;
   logic [7:0]  an;
   logic [6:0]  sev_out;
   logic [2:0]  grant;
   logic        frame_tick;
   int checks = 0, errors = 0;
   typedef struct {logic [7:0] an; logic [6:0] sev; logic [2:0] gr; logic tk;} exp_t;
   exp_t sb[$];
   logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
   int m_own = -1, m_dig = 0, m_fr = 0;
   logic [31:0] m_snap = 0;
   logic [31:0] cur_d [3];
   logic [2:0]  cur_req;

   sevseg_scan_arbiter #(.DWELL_FRAMES(D)) dut (
      .clk_7seg(clk_7seg), .Rst(Rst), .req(req), .data0(data0), .data1(data1), .data2(data2),
      .an(an), .sev_out(sev_out), .grant(grant), .frame_tick(frame_tick));

   always #5 clk_7seg = ~clk_7seg;

   function automatic int top_req(input logic [2:0] r);
      for (int i = 0; i < 3; i++) if (r[i]) return i;
      return -1;
   endfunction

   task automatic model(input logic r, input logic [2:0] rq, input logic [31:0] dv [3]);
      exp_t e;
      int hi;
      if (r) begin
         m_own = -1; m_dig = 0; m_fr = 0; m_snap = 0;
      end else if (m_own < 0) begin
         if (rq != 0) begin
            m_own = top_req(rq); m_dig = 0; m_fr = 0; m_snap = dv[m_own];
         end
      end else if (m_dig < 7) m_dig++;
      else begin
         m_dig = 0;
         m_fr = (m_fr + 1 > D) ? D : m_fr + 1;
         if (!rq[m_own]) begin
            m_own = top_req(rq); m_fr = 0;
         end else if (top_req(rq) < m_own && m_fr == D) begin
            m_own = top_req(rq); m_fr = 0;
         end
         if (m_own >= 0) m_snap = dv[m_own];
      end
      hi = 0;
`ifdef SEVSEG_LZ_BLANK_EN
      for (int k = 0; k < 8; k++) if (((m_snap >> (4*k)) & 32'hF) != 0) hi = k;
`else
      hi = 7;
`endif
      if (m_own < 0 || m_dig > hi) begin
         e.an = 8'hFF; e.sev = 7'h7F;
      end else begin
         e.an = ~(8'(1) << m_dig);
         e.sev = seg_tab[(m_snap >> (4*m_dig)) & 32'hF];
      end
      e.gr = (m_own < 0) ? 3'b000 : 3'(1 << m_own);
      e.tk = m_own >= 0 && m_dig == 7;
      sb.push_back(e);
   endtask

   task automatic cyc(input logic r, input logic [2:0] rq, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      logic [31:0] dv [3];
      @(negedge clk_7seg);
      Rst = r; req = rq; data0 = a; data1 = b; data2 = c;
      dv[0] = a; dv[1] = b; dv[2] = c;
      model(r, rq, dv);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         if (errors <= 30) $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp_v);
      end
   endtask

   initial forever begin
      @(posedge clk_7seg);
      #1;
      if (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("an", 32'(an), 32'(e.an));
         chk("sev_out", 32'(sev_out), 32'(e.sev));
         chk("grant", 32'(grant), 32'(e.gr));
         chk("frame_tick", 32'(frame_tick), 32'(e.tk));
      end
   end

   function automatic logic [31:0] rnd_data();
      return ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 31));
   endfunction

   initial begin
      repeat (2) cyc(1, 0, 0, 0, 0);
      repeat (12) cyc(0, 3'b010, 0, 32'h12345678, 0);
      repeat (2) cyc(1, 0, 0, 0, 0);
      repeat (12) cyc(0, 3'b100, 0, 0, 32'hAAAAAAAA);
      repeat (40) cyc(0, 3'b101, 32'h0BADF00D, 0, 32'hAAAAAAAA);
      repeat (2) cyc(1, 0, 0, 0, 0);
      repeat (12) cyc(0, 3'b110, 0, 32'h11112222, 32'h33334444);
      repeat (12) cyc(0, 3'b100, 0, 32'h11112222, 32'h33334444);
      repeat (3) cyc(0, 3'b000, 0, 0, 0);
      repeat (20) cyc(0, 3'b001, 32'h0, 0, 0);
      repeat (4) cyc(0, 3'b001, 32'h0, 0, 0);
      repeat (12) cyc(0, 3'b001, 32'hFFFFFFFF, 0, 0);
      repeat (6) cyc(0, 3'b001, 32'hFFFFFFFF, 0, 0);
      cyc(1, 3'b001, 32'hFFFFFFFF, 0, 0);
      repeat (18) cyc(0, 3'b001, 32'h000000A5, 0, 0);
      repeat (18) cyc(0, 3'b001, 32'h0, 0, 0);
      cur_req = 0;
      for (int i = 0; i < 3; i++) cur_d[i] = 0;
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 63) == 0) cur_req = 3'($urandom_range(0, 7));
         for (int i = 0; i < 3; i++) if ($urandom_range(0, 7) == 0) cur_d[i] = rnd_data();
         cyc($urandom_range(0, 599) == 0, cur_req, cur_d[0], cur_d[1], cur_d[2]);
      end
      repeat (3) @(posedge clk_7seg);
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sevseg_scan_arbiter.md
SEVSEG_SCAN_ARBITER -- requirements
Module: sevseg_scan_arbiter

Interface
REQ-001 SHALL have parameter DWELL_FRAMES, default 4, minimum number of complete frames an owner keeps the display before a higher-priority requester may preempt it (legal range 1..15).
REQ-002 SHALL have port clk_7seg  input  1  scan clock; all state updates on its rising edge.
REQ-003 SHALL have port Rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req  input  3  display requests: bit0 core debug (highest priority), bit1 MMIO display, bit2 UART status (lowest).
REQ-005 SHALL have port data0, data1, data2  input  32 each  hex value for requester 0/1/2; nibble k shows on digit k.
REQ-006 SHALL have port an  output  8  digit enables, active-low, one-hot-low.
REQ-007 SHALL have port sev_out  output  7  segment pattern, active-low.
REQ-008 SHALL have port grant  output  3  one-hot current owner; 3'b000 when idle.
REQ-009 SHALL have port frame_tick  output  1  one-cycle pulse on the last digit (index 7) of each frame.

Function
REQ-010 SHALL implement states IDLE and SCAN, plus 3-bit digit index dig, 32-bit snapshot snap, and dwell counter dwell.
REQ-011 IDLE: an=8'hFF, sev_out=7'h7F, grant=0; when req!=0, next cycle SHALL enter SCAN with dig=0, dwell=0, grant=highest-priority set bit, snap=that requester's data.
REQ-012 SCAN: an SHALL be ~(8'b1<<dig) and sev_out SHALL be the decode of snap[4*dig+:4] in the same cycle (combinational from registers).
REQ-013 Decode SHALL be 0->0000001, 1->1001111, 2->0010010, 3->0000110, 4->1001100, 5->0100100, 6->0100000, 7->0001111, 8->0000000, 9->0000100, A->0001000, b->1100000, C->0110001, d->1000010, E->0110000, F->0111000.
REQ-014 dig SHALL increment by one every SCAN cycle and wrap 7->0; a frame is 8 cycles.
REQ-015 snap SHALL change only on a frame boundary (dig==7 -> 0); mid-frame changes on dataN SHALL NOT appear until the next frame.
REQ-016 At each boundary, dwell SHALL increment, saturating at DWELL_FRAMES.
REQ-017 Boundary arbitration: owner req low and other req pending -> grant highest-priority pending, dwell=0, no IDLE cycle.
REQ-018 Boundary: owner req low and req==0 -> IDLE next cycle.
REQ-019 Boundary: owner still requesting, higher-priority req pending, dwell reaches DWELL_FRAMES at this boundary -> preempt to highest pending, dwell=0; otherwise owner retained.
REQ-020 Lower-priority requests SHALL never preempt an owner still requesting.
REQ-021 On every boundary snap SHALL load data of the owner for the next frame (new or retained).
REQ-022 frame_tick SHALL be 1 exactly when state==SCAN and dig==7.
REQ-023 Request changes mid-frame SHALL have no effect until the boundary.

Reset
REQ-024 Rst high on a clock edge SHALL force IDLE, dig=0, dwell=0, snap=0, grant=0, an=8'hFF, sev_out=7'h7F, frame_tick=0, including mid-frame; outputs hold those values while Rst high.
REQ-025 First grant after Rst deasserts SHALL follow REQ-011.

Configuration
REQ-026 Macro SEVSEG_LZ_BLANK_EN SHALL select leading-zero blanking.
REQ-027 With SEVSEG_LZ_BLANK_EN defined: in SCAN, digits above the highest nonzero nibble of snap SHALL drive an bit high and sev_out=7'h7F; digit 0 always lit (snap==0 shows single "0"); dig sequencing and frame timing unchanged.
REQ-028 Without SEVSEG_LZ_BLANK_EN: all eight digits SHALL be lit every frame.

Verification
REQ-029 Reset then req=3'b010, data1=32'h12345678 -> grant=3'b010 next cycle; over following 8 cycles an=FE,FD,...,7F with sev_out for 8,7,6,5,4,3,2,1; frame_tick on 8th.
REQ-030 DWELL_FRAMES=4, owner req2 (data2=32'hAAAAAAAA); assert req0 after frame 1 -> grant switches to 3'b001 only at 4th boundary after grant2.
REQ-031 Owner req1, drop req1 mid-frame with req2 high -> frame completes with data1, grant=3'b100 next cycle, no IDLE cycle.
REQ-032 Change data0 from 32'h0 to 32'hFFFFFFFF at dig==3 -> digits 3..7 still show 0 this frame, F from next frame.
REQ-033 Assert Rst at dig==5 -> next cycle an=8'hFF, sev_out=7'h7F, grant=0, frame_tick=0.
REQ-034 SEVSEG_LZ_BLANK_EN defined, data0=32'h000000A5 -> only an bits 0,1 ever low (A on digit 1, 5 on digit 0); data0=0 -> only digit 0 lit showing 0000001.
